// File: rtl/krnl_cam_pkg.sv
// Shared CAM-kernel definitions: command opcodes, header field layout and
// the requester-arbiter state encoding.
package krnl_cam_pkg;

  // CAM command opcodes carried in the low bits of the header beat
  localparam int IDLE       = 0;
  localparam int UPDATE_ALL = 1;
  localparam int SEARCH     = 2;
  localparam int UPDATE_ONE = 3;

  // Header field positions
  localparam int OPCODE_LSB = 0;
  localparam int LEN_LSB    = 32;
  localparam int LEN_MSB    = 61;

  typedef enum logic [1:0] {ARB, HDR, BODY, DONE} arb_state_e;

  // IDLE is a valid encoding but never a command; anything above
  // UPDATE_ONE is unassigned.
  function automatic logic op_legal(input logic [7:0] op);
    case (op)
      8'(IDLE):                               op_legal = 1'b0;
      8'(UPDATE_ALL), 8'(SEARCH), 8'(UPDATE_ONE): op_legal = 1'b1;
      default:                                op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/krnl_cam_req_arbiter_if.sv
// Bus bundle around the arbiter: NUM_REQ requester streams in, one CAM
// command stream out with owner id and last-beat sideband.
interface krnl_cam_req_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int C_DATA_WIDTH = 512
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ*C_DATA_WIDTH-1:0] s_tdata;
  logic [NUM_REQ-1:0]              s_tvalid;
  logic [NUM_REQ-1:0]              s_tready;
  logic [C_DATA_WIDTH-1:0]         m_tdata;
  logic                            m_tvalid;
  logic                            m_tready;
  logic [ID_W-1:0]                 m_tid;
  logic                            m_tlast;

  // master: requesters plus CAM sink; slave: the arbiter itself
  modport master (
    output s_tdata, s_tvalid, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tid, m_tlast
  );

  modport slave (
    input  s_tdata, s_tvalid, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tid, m_tlast
  );

endinterface

// File: rtl/krnl_cam_skid_buf.sv
// Two-entry register FIFO. Head entry drives the output directly so the
// presented beat never changes while stalled.
module krnl_cam_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             ap_clk,
  input  logic             areset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] q0, q1;
  logic [1:0]       cnt;
  logic             push, pop;

  // Full buffer can still take a beat when the head leaves this cycle
  assign in_ready  = (cnt != 2'd2) || out_ready;
  assign out_valid = (cnt != 2'd0);
  assign out_data  = q0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Shift-style storage: q0 is always the oldest beat
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      q0  <= '0;
      q1  <= '0;
      cnt <= 2'd0;
    end else begin
      case ({push, pop})
        2'b11: begin
          if (cnt == 2'd1) begin
            q0 <= in_data;
          end else begin
            q0 <= q1;
            q1 <= in_data;
          end
        end
        2'b10: begin
          if (cnt == 2'd0) q0 <= in_data;
          else             q1 <= in_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          q0  <= q1;
          cnt <= cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/krnl_cam_req_arbiter.sv
// Round-robin, command-locked arbiter feeding the CAM p0 stream. One
// requester owns the output from header to last payload beat; illegal
// headers are swallowed with an error pulse.
module krnl_cam_req_arbiter
  import krnl_cam_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int C_DATA_WIDTH  = 512,
  parameter int OP_CODE_WIDTH = 3,   // up to 8
  parameter int LEN_WIDTH     = 30
) (
  input  logic                 ap_clk,
  input  logic                 areset,
  krnl_cam_req_arbiter_if.slave bus,
  output logic                 busy,
  output logic                 err_pulse,
  output logic [31:0]          pkt_count
);

  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SKID_W = C_DATA_WIDTH + ID_W + 1;

  arb_state_e               state;
  logic [ID_W-1:0]          owner, rr_ptr, pick, rr_next;
  logic [LEN_WIDTH-1:0]     cnt, hdr_len;
  logic                     fwd;
  logic [C_DATA_WIDTH-1:0]  cur_data;
  logic [OP_CODE_WIDTH-1:0] hdr_op;
  logic                     cur_valid, in_port, acc, hdr_legal;
  logic                     skid_ready, push, push_last, any_valid;
  logic [SKID_W-1:0]        skid_in, skid_out;

  // First valid port at or after ptr, wrapping around
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                              input logic [ID_W-1:0]    ptr);
    logic found;
    int   idx;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && v[ID_W'(idx)]) begin
        rr_pick = ID_W'(idx);
        found   = 1'b1;
      end
    end
  endfunction

  assign any_valid = |bus.s_tvalid;
  assign pick      = rr_pick(bus.s_tvalid, rr_ptr);
  assign rr_next   = (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  assign cur_data  = bus.s_tdata[int'(owner)*C_DATA_WIDTH +: C_DATA_WIDTH];
  assign cur_valid = bus.s_tvalid[owner];
  assign in_port   = (state == HDR) || (state == BODY);
  assign acc       = in_port && cur_valid && skid_ready;

  assign hdr_op    = cur_data[OPCODE_LSB +: OP_CODE_WIDTH];
  assign hdr_legal = op_legal(8'(hdr_op));
  assign hdr_len   = LEN_WIDTH'(cur_data[LEN_MSB:LEN_LSB]);

  // Illegal headers are consumed but never reach the CAM
  assign push      = acc && ((state == BODY) || hdr_legal);
  assign push_last = (state == HDR) ? (hdr_len == '0) : (cnt == LEN_WIDTH'(1));
  assign skid_in   = {push_last, owner, cur_data};

  // Only the owning port sees ready, and only while its command is open
  always_comb begin
    bus.s_tready = '0;
    if (in_port) bus.s_tready[owner] = skid_ready;
  end

  // Arbitration / command-tracking FSM with registered status outputs
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state     <= ARB;
      owner     <= '0;
      rr_ptr    <= '0;
      cnt       <= '0;
      fwd       <= 1'b0;
      busy      <= 1'b0;
      err_pulse <= 1'b0;
      pkt_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        ARB: begin
          if (any_valid) begin
            owner <= pick;
            busy  <= 1'b1;
            state <= HDR;
          end
        end
        HDR: begin
          if (acc) begin
            if (hdr_legal) begin
              cnt <= hdr_len;
              fwd <= 1'b1;
              if (hdr_len == '0) begin
                busy  <= 1'b0;
                state <= DONE;
              end else begin
                state <= BODY;
              end
            end else begin
              fwd       <= 1'b0;
              err_pulse <= 1'b1;
              busy      <= 1'b0;
              state     <= DONE;
            end
          end
        end
        BODY: begin
          if (acc) begin
            if (cnt != '0) cnt <= cnt - LEN_WIDTH'(1);
            if (cnt == LEN_WIDTH'(1)) begin
              busy  <= 1'b0;
              state <= DONE;
            end
          end
        end
        DONE: begin
          rr_ptr <= rr_next;
          if (fwd) pkt_count <= pkt_count + 32'd1;
          state <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

  krnl_cam_skid_buf #(.WIDTH(SKID_W)) u_skid (
    .ap_clk    (ap_clk),
    .areset    (areset),
    .in_data   (skid_in),
    .in_valid  (push),
    .in_ready  (skid_ready),
    .out_data  (skid_out),
    .out_valid (bus.m_tvalid),
    .out_ready (bus.m_tready)
  );

  assign {bus.m_tlast, bus.m_tid, bus.m_tdata} = skid_out;

endmodule

// File: tb/tb_krnl_cam_req_arbiter.sv
// Directed bench for krnl_cam_req_arbiter: drives requester commands,
// records both sides of the arbiter and checks against hand-built beats.
module tb_krnl_cam_req_arbiter;
  import krnl_cam_pkg::*;

  localparam int NR = 4;
  localparam int DW = 512;

  logic        ap_clk = 1'b0;
  logic        areset = 1'b1;
  logic        busy, err_pulse;
  logic [31:0] pkt_count;

  krnl_cam_req_arbiter_if #(.NUM_REQ(NR), .C_DATA_WIDTH(DW)) bus ();

  krnl_cam_req_arbiter #(
    .NUM_REQ(NR), .C_DATA_WIDTH(DW), .OP_CODE_WIDTH(3), .LEN_WIDTH(30)
  ) dut (
    .ap_clk    (ap_clk),
    .areset    (areset),
    .bus       (bus),
    .busy      (busy),
    .err_pulse (err_pulse),
    .pkt_count (pkt_count)
  );

  always #5 ap_clk = ~ap_clk;

  logic [DW-1:0] tx_data  [NR];
  logic          tx_valid [NR];

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      bus.s_tdata[i*DW +: DW] = tx_data[i];
      bus.s_tvalid[i]         = tx_valid[i];
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  typedef struct { int cyc; int tid; logic last; logic [DW-1:0] data; } mbeat_t;
  typedef struct { int cyc; int port; } sacc_t;

  mbeat_t mq[$];
  sacc_t  sq[$];
  int     cyc = 0;
  int     n_err = 0;
  int     occ = 0;
  int     n_full = 0;
  logic   bp_mode = 1'b0;

  logic [DW-1:0] pv_data;
  logic          pv_valid = 1'b0, pv_ready = 1'b1, pv_last = 1'b0;
  logic [1:0]    pv_tid = '0;

  always @(posedge ap_clk) cyc <= cyc + 1;

  // sample one time unit before each rising edge
  always begin : mon
    mbeat_t mb;
    sacc_t  sa;
    @(negedge ap_clk);
    #4;
    if (!areset) begin
      if (pv_valid && !pv_ready) begin
        chk("stall_data", bus.m_tdata, pv_data);
        chk("stall_vld_tid_last", {bus.m_tvalid, bus.m_tid, bus.m_tlast}, {1'b1, pv_tid, pv_last});
      end
      for (int p = 0; p < NR; p++) begin
        if (bus.s_tvalid[p] && bus.s_tready[p]) begin
          sa.cyc = cyc; sa.port = p;
          sq.push_back(sa);
        end
      end
      if (bus.m_tvalid && bus.m_tready) begin
        mb.cyc = cyc; mb.tid = int'(bus.m_tid); mb.last = bus.m_tlast; mb.data = bus.m_tdata;
        mq.push_back(mb);
      end
      if (err_pulse) n_err++;
      if (bp_mode) begin
        chk("occ_valid", bus.m_tvalid, occ != 0);
        if (occ == 2 && !bus.m_tready) begin
          n_full++;
          chk("sready_full", bus.s_tready[1], 0);
        end
        occ = occ + int'(|(bus.s_tvalid & bus.s_tready)) - int'(bus.m_tvalid & bus.m_tready);
      end
    end
    pv_valid = bus.m_tvalid && !areset;
    pv_ready = bus.m_tready;
    pv_data  = bus.m_tdata;
    pv_tid   = bus.m_tid;
    pv_last  = bus.m_tlast;
  end

  function automatic logic [DW-1:0] mk_hdr(input int op, input int len, input int tag);
    logic [DW-1:0] d;
    d = '0;
    d[2:0]     = 3'(op);
    d[61:32]   = 30'(len);
    d[127:64]  = 64'(tag);
    d[511:480] = 32'hC0DE_0000;
    return d;
  endfunction

  function automatic logic [DW-1:0] mk_pay(input int tag, input int i);
    logic [DW-1:0] d;
    d = '0;
    d[31:0]    = 32'h1000 + 32'(i);
    d[127:64]  = 64'(tag);
    d[511:480] = 32'hBEEF_0000 + 32'(i);
    return d;
  endfunction

  task automatic send_beat(input int p, input logic [DW-1:0] d);
    int   tries;
    logic ok;
    tries = 0;
    ok    = 1'b0;
    @(negedge ap_clk);
    tx_valid[p] = 1'b1;
    tx_data[p]  = d;
    while (!ok && tries < 200) begin
      #1;
      if (bus.s_tready[p]) ok = 1'b1;
      else begin
        @(negedge ap_clk);
        tries++;
      end
    end
    if (!ok) chk($sformatf("accept_timeout_p%0d", p), ok, 1);
  endtask

  task automatic send_cmd(input int p, input int op, input int len, input int tag);
    send_beat(p, mk_hdr(op, len, tag));
    for (int i = 0; i < len; i++) send_beat(p, mk_pay(tag, i));
    @(negedge ap_clk);
    tx_valid[p] = 1'b0;
  endtask

  task automatic check_cmd(input string t, input int idx, input int p, input int op,
                           input int len, input int tag);
    for (int k = 0; k <= len; k++) begin
      if (idx + k >= mq.size()) begin
        chk({t, "_beat_count"}, mq.size(), idx + len + 1);
        return;
      end
      chk({t, "_data"}, mq[idx+k].data, (k == 0) ? mk_hdr(op, len, tag) : mk_pay(tag, k - 1));
      chk({t, "_tid"}, mq[idx+k].tid, p);
      chk({t, "_last"}, mq[idx+k].last, k == len);
    end
  endtask

  task automatic do_reset();
    @(negedge ap_clk);
    areset = 1'b1;
    bus.m_tready = 1'b1;
    for (int i = 0; i < NR; i++) tx_valid[i] = 1'b0;
    repeat (2) @(negedge ap_clk);
    areset = 1'b0;
    mq.delete();
    sq.delete();
    n_err = 0;
    occ   = 0;
  endtask

  task automatic chk_reset_outputs(input string t);
    chk({t, "_s_tready"},  bus.s_tready, 0);
    chk({t, "_m_tvalid"},  bus.m_tvalid, 0);
    chk({t, "_m_tdata"},   bus.m_tdata, 0);
    chk({t, "_m_tid"},     bus.m_tid, 0);
    chk({t, "_m_tlast"},   bus.m_tlast, 0);
    chk({t, "_busy"},      busy, 0);
    chk({t, "_err_pulse"}, err_pulse, 0);
    chk({t, "_pkt_count"}, pkt_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus.m_tready = 1'b1;
    for (int i = 0; i < NR; i++) begin
      tx_valid[i] = 1'b0;
      tx_data[i]  = '0;
    end
    repeat (3) @(negedge ap_clk);
    chk_reset_outputs("rst");
    areset = 1'b0;
    mq.delete();
    sq.delete();

    // single SEARCH, LEN=3, from port 0
    send_cmd(0, SEARCH, 3, 1);
    repeat (6) @(negedge ap_clk);
    chk("t1_sacc", sq.size(), 4);
    chk("t1_beats", mq.size(), 4);
    check_cmd("t1", 0, 0, SEARCH, 3, 1);
    chk("t1_pkt", pkt_count, 1);
    if (sq.size() > 0 && mq.size() > 0) chk("t1_latency", mq[0].cyc, sq[0].cyc + 1);

    // four contending ports, port 0 twice
    do_reset();
    fork
      begin
        send_cmd(0, UPDATE_ONE, 1, 16);
        send_cmd(0, UPDATE_ONE, 1, 17);
      end
      send_cmd(1, UPDATE_ONE, 1, 32);
      send_cmd(2, UPDATE_ONE, 1, 48);
      send_cmd(3, UPDATE_ONE, 1, 64);
    join
    repeat (6) @(negedge ap_clk);
    chk("t3_sacc", sq.size(), 10);
    if (sq.size() == 10) begin
      int exp_port [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
      for (int i = 0; i < 10; i++) chk($sformatf("t3_grant%0d", i), sq[i].port, exp_port[i]);
      chk("t3_gap01", sq[2].cyc - sq[1].cyc, 3);
      chk("t3_gap30", sq[8].cyc - sq[7].cyc, 3);
    end
    check_cmd("t3_p0a", 0, 0, UPDATE_ONE, 1, 16);
    check_cmd("t3_p1",  2, 1, UPDATE_ONE, 1, 32);
    check_cmd("t3_p2",  4, 2, UPDATE_ONE, 1, 48);
    check_cmd("t3_p3",  6, 3, UPDATE_ONE, 1, 64);
    check_cmd("t3_p0b", 8, 0, UPDATE_ONE, 1, 17);
    chk("t3_pkt", pkt_count, 5);

    // illegal opcode from port 2, then ports 0 and 3 contend
    do_reset();
    send_cmd(2, 5, 0, 80);
    repeat (4) @(negedge ap_clk);
    chk("t4_err_cycles", n_err, 1);
    chk("t4_no_beat", mq.size(), 0);
    chk("t4_pkt_hold", pkt_count, 0);
    sq.delete();
    fork
      send_cmd(0, SEARCH, 0, 81);
      send_cmd(3, SEARCH, 0, 82);
    join
    repeat (5) @(negedge ap_clk);
    chk("t4_sacc", sq.size(), 2);
    if (sq.size() == 2) begin
      chk("t4_first_port", sq[0].port, 3);
      chk("t4_second_port", sq[1].port, 0);
    end
    check_cmd("t4_p3", 0, 3, SEARCH, 0, 82);
    check_cmd("t4_p0", 1, 0, SEARCH, 0, 81);
    chk("t4_pkt", pkt_count, 2);

    // UPDATE_ALL LEN=8 under m_tready pattern 1,0,0,1
    do_reset();
    bp_mode = 1'b1;
    n_full  = 0;
    fork
      send_cmd(1, UPDATE_ALL, 8, 96);
      begin
        for (int k = 0; k < 40; k++) begin
          @(negedge ap_clk);
          bus.m_tready = (k % 4 == 0) || (k % 4 == 3);
        end
      end
    join
    @(negedge ap_clk);
    bus.m_tready = 1'b1;
    repeat (4) @(negedge ap_clk);
    bp_mode = 1'b0;
    chk("t5_beats", mq.size(), 9);
    check_cmd("t5", 0, 1, UPDATE_ALL, 8, 96);
    chk("t5_pkt", pkt_count, 1);
    chk("t5_full_seen", n_full > 0, 1);

    // header-only SEARCH from port 2
    mq.delete();
    send_cmd(2, SEARCH, 0, 112);
    repeat (5) @(negedge ap_clk);
    chk("t6_beats", mq.size(), 1);
    check_cmd("t6", 0, 2, SEARCH, 0, 112);
    chk("t6_busy", busy, 0);
    chk("t6_pkt", pkt_count, 2);

    // reset during payload beat 2 of a LEN=5 command
    do_reset();
    send_beat(0, mk_hdr(UPDATE_ALL, 5, 128));
    send_beat(0, mk_pay(128, 0));
    @(negedge ap_clk);
    tx_data[0] = mk_pay(128, 1);
    areset = 1'b1;
    @(negedge ap_clk);
    chk_reset_outputs("t7_rst");
    tx_valid[0] = 1'b0;
    areset = 1'b0;
    mq.delete();
    sq.delete();
    send_cmd(1, UPDATE_ONE, 2, 144);
    repeat (6) @(negedge ap_clk);
    chk("t7_beats", mq.size(), 3);
    check_cmd("t7", 0, 1, UPDATE_ONE, 2, 144);
    chk("t7_pkt", pkt_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
